// File: rtl/alu_result_seq.sv
// alu_result_seq: result stage behind the ALU.
// Captures the 64-bit {hi,lo} result, the destination and the width in one
// cycle, holds the condition flags, and then drives the result onto the
// shared 32-bit bus through a request/grant handshake.
// Wide ops (MUL/DIV) send HI then LO; narrow ops send a single GPR write.
module alu_result_seq #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iLoad,
  input  logic [DATA_W-1:0] iC_hi,
  input  logic [DATA_W-1:0] iC_lo,
  input  logic              iZero,
  input  logic              iNeg,
  input  logic              iWide,
  input  logic              iSetCC,
  input  logic [REG_AW-1:0] iDest,
  input  logic              iGrant,
  input  logic              iClrOvr,
  output logic              oReady,
  output logic              oBusReq,
  output logic [DATA_W-1:0] oBus,
  output logic              oHiWr,
  output logic              oLoWr,
  output logic              oRegWr,
  output logic [REG_AW-1:0] oRegAddr,
  output logic              oCC_Z,
  output logic              oCC_N,
  output logic              oDone,
  output logic              oOvr
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_HI = 2'd1,
    ST_SEND_LO = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [REG_AW-1:0]   dest_q;
  logic                wide_q;
  logic                cc_z_q, cc_n_q;
  logic                ovr_q;

  // A load is accepted only while idle; anything else is an overrun.
  logic                capture_s;
  logic                overrun_s;

  assign capture_s = iLoad && (state_q == ST_IDLE);
  assign overrun_s = iLoad && (state_q != ST_IDLE);

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and bus/strobe outputs; strobes follow iGrant within the cycle.
  always_comb begin
    state_d  = state_q;
    oReady   = 1'b0;
    oBusReq  = 1'b0;
    oBus     = {DATA_W{1'b0}};
    oHiWr    = 1'b0;
    oLoWr    = 1'b0;
    oRegWr   = 1'b0;
    oRegAddr = {REG_AW{1'b0}};
    oDone    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        oReady = 1'b1;
        if (iLoad) begin
          state_d = iWide ? ST_SEND_HI : ST_SEND_LO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND_HI: begin
        oBusReq = 1'b1;
        oBus    = hi_q;
        oHiWr   = iGrant;
        if (iGrant) begin
          state_d = ST_SEND_LO;
        end else begin
          state_d = ST_SEND_HI;
        end
      end
      ST_SEND_LO: begin
        oBusReq = 1'b1;
        oBus    = lo_q;
        oDone   = iGrant;
        if (wide_q) begin
          oLoWr = iGrant;
        end else begin
          oRegWr   = iGrant;
          oRegAddr = dest_q;
        end
        if (iGrant) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND_LO;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result capture: words, destination and width are latched only on an accepted load.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      hi_q   <= {DATA_W{1'b0}};
      lo_q   <= {DATA_W{1'b0}};
      dest_q <= {REG_AW{1'b0}};
      wide_q <= 1'b0;
    end else if (capture_s) begin
      hi_q   <= iC_hi;
      lo_q   <= iC_lo;
      dest_q <= iDest;
      wide_q <= iWide;
    end else begin
      hi_q   <= hi_q;
      lo_q   <= lo_q;
      dest_q <= dest_q;
      wide_q <= wide_q;
    end
  end

  // Condition flags: written only on an accepted load that asks for a CC update.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cc_z_q <= 1'b0;
      cc_n_q <= 1'b0;
    end else if (capture_s && iSetCC) begin
      cc_z_q <= iZero;
      cc_n_q <= iNeg;
    end else begin
      cc_z_q <= cc_z_q;
      cc_n_q <= cc_n_q;
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ovr_q <= 1'b0;
    end else if (overrun_s) begin
      ovr_q <= 1'b1;
    end else if (iClrOvr) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_q;
    end
  end

  assign oCC_Z = cc_z_q;
  assign oCC_N = cc_n_q;
  assign oOvr  = ovr_q;

endmodule

// File: tb/tb_alu_result_seq.sv
// Self-checking bench for alu_result_seq.
// The reference model keeps a queue of pending bus transfers: an accepted
// load pushes HI+LO (wide) or one GPR entry (narrow); a granted cycle pops
// the head. Every output is derived from that queue and the current inputs.
module tb_alu_result_seq;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          iClk;
  logic          iRst;
  logic          iLoad;
  logic [DW-1:0] iC_hi;
  logic [DW-1:0] iC_lo;
  logic          iZero;
  logic          iNeg;
  logic          iWide;
  logic          iSetCC;
  logic [AW-1:0] iDest;
  logic          iGrant;
  logic          iClrOvr;
  logic          oReady;
  logic          oBusReq;
  logic [DW-1:0] oBus;
  logic          oHiWr;
  logic          oLoWr;
  logic          oRegWr;
  logic [AW-1:0] oRegAddr;
  logic          oCC_Z;
  logic          oCC_N;
  logic          oDone;
  logic          oOvr;

  alu_result_seq #(.DATA_W(DW), .REG_AW(AW)) dut (
    .iClk(iClk), .iRst(iRst), .iLoad(iLoad), .iC_hi(iC_hi), .iC_lo(iC_lo),
    .iZero(iZero), .iNeg(iNeg), .iWide(iWide), .iSetCC(iSetCC), .iDest(iDest),
    .iGrant(iGrant), .iClrOvr(iClrOvr), .oReady(oReady), .oBusReq(oBusReq),
    .oBus(oBus), .oHiWr(oHiWr), .oLoWr(oLoWr), .oRegWr(oRegWr),
    .oRegAddr(oRegAddr), .oCC_Z(oCC_Z), .oCC_N(oCC_N), .oDone(oDone), .oOvr(oOvr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef enum int {K_HI, K_LO, K_GPR} kind_e;
  typedef struct {
    logic [DW-1:0] d;
    kind_e         kind;
    logic [AW-1:0] addr;
  } xfer_t;

  xfer_t m_q[$];
  logic  m_z, m_n, m_ovr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_z = 1'b0;
    m_n = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Compare every output against the model (called away from the clock edge).
  task automatic check_model();
    logic          busy;
    logic [DW-1:0] e_bus;
    logic          e_hi, e_lo, e_reg, e_done;
    logic [AW-1:0] e_addr;
    busy = (m_q.size() != 0);
    e_bus = '0; e_hi = 1'b0; e_lo = 1'b0; e_reg = 1'b0; e_done = 1'b0; e_addr = '0;
    if (busy) begin
      e_bus  = m_q[0].d;
      e_hi   = iGrant && (m_q[0].kind == K_HI);
      e_lo   = iGrant && (m_q[0].kind == K_LO);
      e_reg  = iGrant && (m_q[0].kind == K_GPR);
      e_done = iGrant && (m_q[0].kind != K_HI);
      e_addr = (m_q[0].kind == K_GPR) ? m_q[0].addr : '0;
    end
    chk("ready",   64'(oReady),   64'(!busy));
    chk("busreq",  64'(oBusReq),  64'(busy));
    chk("bus",     64'(oBus),     64'(e_bus));
    chk("hiwr",    64'(oHiWr),    64'(e_hi));
    chk("lowr",    64'(oLoWr),    64'(e_lo));
    chk("regwr",   64'(oRegWr),   64'(e_reg));
    chk("regaddr", 64'(oRegAddr), 64'(e_addr));
    chk("done",    64'(oDone),    64'(e_done));
    chk("cc_z",    64'(oCC_Z),    64'(m_z));
    chk("cc_n",    64'(oCC_N),    64'(m_n));
    chk("ovr",     64'(oOvr),     64'(m_ovr));
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic advance();
    logic was_ready;
    xfer_t x;
    @(posedge iClk);
    was_ready = (m_q.size() == 0);
    if (!was_ready && iGrant) void'(m_q.pop_front());
    if (iLoad && was_ready) begin
      if (iWide) begin
        x.d = iC_hi; x.kind = K_HI;  x.addr = '0; m_q.push_back(x);
        x.d = iC_lo; x.kind = K_LO;  x.addr = '0; m_q.push_back(x);
      end else begin
        x.d = iC_lo; x.kind = K_GPR; x.addr = iDest; m_q.push_back(x);
      end
      if (iSetCC) begin
        m_z = iZero;
        m_n = iNeg;
      end
    end
    if (iLoad && !was_ready) m_ovr = 1'b1;
    else if (iClrOvr) m_ovr = 1'b0;
    #1;
  endtask

  task automatic settle();
    @(negedge iClk);
    check_model();
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    iLoad = 1'b0; iC_hi = '0; iC_lo = '0; iZero = 1'b0; iNeg = 1'b0;
    iWide = 1'b0; iSetCC = 1'b0; iDest = '0; iGrant = 1'b0; iClrOvr = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          wide;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic [AW-1:0] dest;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
    logic [AW-1:0] exp_addr;
    int            exp_len;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0005, 4'd3, 32'h0000_0005, 32'h0000_0005, 4'd3, 1};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'd0, 2};
    vecs[2] = '{1'b0, 32'hDEAD_BEEF, 32'h8000_0000, 4'd15, 32'h8000_0000, 32'h8000_0000, 4'd15, 1};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'd1, 32'h0000_0000, 32'h1234_5678, 4'd0, 2};

    idle_inputs();
    iRst = 1'b1;
    model_reset();
    #12;
    // reset state
    chk("rst_ready",  64'(oReady),  64'(1'b1));
    chk("rst_busreq", 64'(oBusReq), 64'(1'b0));
    chk("rst_bus",    64'(oBus),    64'(32'h0));
    chk("rst_ovr",    64'(oOvr),    64'(1'b0));
    @(negedge iClk);
    iRst = 1'b0;
    advance();

    // table: load with grant held high, walk the transfers
    for (int v = 0; v < 4; v++) begin
      iLoad = 1'b1; iWide = vecs[v].wide; iC_hi = vecs[v].hi; iC_lo = vecs[v].lo;
      iDest = vecs[v].dest; iGrant = 1'b1;
      cycle();
      iLoad = 1'b0;
      for (int k = 0; k < vecs[v].exp_len; k++) begin
        settle();
        if (k == 0) chk("tbl_first", 64'(oBus), 64'(vecs[v].exp_first));
        if (k == vecs[v].exp_len - 1) begin
          chk("tbl_last",  64'(oBus),     64'(vecs[v].exp_last));
          chk("tbl_addr",  64'(oRegAddr), 64'(vecs[v].exp_addr));
          chk("tbl_done",  64'(oDone),    64'(1'b1));
        end
        advance();
      end
      settle();
      chk("tbl_idle", 64'(oReady), 64'(1'b1));
      advance();
    end

    // stall: wide load, grant low for 3 cycles, then resume
    idle_inputs();
    iLoad = 1'b1; iWide = 1'b1; iC_hi = 32'hA5A5_0001; iC_lo = 32'h5A5A_0002;
    cycle();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("stall_bus", 64'(oBus), 64'(32'hA5A5_0001));
      chk("stall_hiwr", 64'(oHiWr), 64'(1'b0));
      advance();
    end
    iGrant = 1'b1;
    cycle();
    cycle();

    // overrun: load during SEND_HI ignored, then load+clear while busy keeps it set
    idle_inputs();
    iLoad = 1'b1; iWide = 1'b1; iC_hi = 32'h1111_1111; iC_lo = 32'h2222_2222;
    cycle();
    iC_hi = 32'h3333_3333; iC_lo = 32'h4444_4444;   // iLoad still high, stage busy
    cycle();
    iClrOvr = 1'b1;
    cycle();
    settle();
    chk("ovr_sticky", 64'(oOvr), 64'(1'b1));
    chk("ovr_orig_hi", 64'(oBus), 64'(32'h1111_1111));
    advance();
    idle_inputs();
    iGrant = 1'b1;
    cycle();
    settle();
    chk("ovr_orig_lo", 64'(oBus), 64'(32'h2222_2222));
    advance();
    iClrOvr = 1'b1; iGrant = 1'b0;
    cycle();
    chk("ovr_cleared", 64'(oOvr), 64'(1'b0));

    // CC: update with SetCC, then hold without it
    idle_inputs();
    iLoad = 1'b1; iZero = 1'b1; iNeg = 1'b0; iSetCC = 1'b1; iGrant = 1'b1;
    cycle();
    iLoad = 1'b0;
    cycle();
    chk("cc_set_z", 64'(oCC_Z), 64'(1'b1));
    iLoad = 1'b1; iZero = 1'b0; iNeg = 1'b1; iSetCC = 1'b0;
    cycle();
    iLoad = 1'b0;
    cycle();
    chk("cc_hold_z", 64'(oCC_Z), 64'(1'b1));
    chk("cc_hold_n", 64'(oCC_N), 64'(1'b0));

    // reset mid-op in SEND_LO
    idle_inputs();
    iLoad = 1'b1; iWide = 1'b1; iC_hi = 32'hCAFE_0000; iC_lo = 32'hCAFE_0001;
    iSetCC = 1'b1; iZero = 1'b1; iNeg = 1'b1;
    cycle();
    idle_inputs();
    iGrant = 1'b1;
    cycle();                 // HI granted, now in SEND_LO
    iGrant = 1'b0;
    settle();
    chk("pre_rst_busreq", 64'(oBusReq), 64'(1'b1));
    #2;
    iRst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_busreq", 64'(oBusReq), 64'(1'b0));
    chk("mid_rst_bus",    64'(oBus),    64'(32'h0));
    chk("mid_rst_ccz",    64'(oCC_Z),   64'(1'b0));
    chk("mid_rst_ccn",    64'(oCC_N),   64'(1'b0));
    chk("mid_rst_ready",  64'(oReady),  64'(1'b1));
    @(negedge iClk);
    iRst = 1'b0;
    advance();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      iLoad   = ($urandom_range(0, 99) < 45);
      iGrant  = ($urandom_range(0, 99) < 60);
      iClrOvr = ($urandom_range(0, 99) < 10);
      iWide   = $urandom_range(0, 1);
      iSetCC  = $urandom_range(0, 1);
      iZero   = $urandom_range(0, 1);
      iNeg    = $urandom_range(0, 1);
      iDest   = AW'($urandom_range(0, 15));
      iC_hi   = $urandom;
      iC_lo   = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
